wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage MIPS pipeline, and the writer side of the register-file port that the decode stage reads. It holds the MEM/WB pipeline register and extracts and extends sub-word load data. It selects the final result and drives the register file's write port (RegWriteW, WriteRegW, ResultW), the same signals decode uses for its write-through bypass. It also keeps a retired-instruction counter.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- CLK  in  1  pipeline clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- StallW  in  1  hold the MEM/WB register (no capture, no retire count)
- FlushW  in  1  capture a bubble instead of the M-stage instruction
- ValidM  in  1  M-stage slot holds a real instruction
- RegWriteM  in  1  instruction writes a register
- WriteRegM  in  5  destination register number
- ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 link (PC+8), 11 reserved (treated as ALU)
- LoadSizeM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- LoadUnsignedM  in  1  1 = zero-extend sub-word load, 0 = sign-extend
- ALUOutM  in  32  ALU result; bits [1:0] are the load byte offset
- ReadDataM  in  32  raw data-memory word
- PCPlus8M  in  32  link address
- ValidW  out  1  W-stage slot holds a real instruction
- RegWriteW  out  1  register-file write enable
- WriteRegW  out  5  register-file write address
- ResultW  out  32  register-file write data
- InstRetW  out  CNT_W  count of retired instructions

## Operation
- Pipeline register captures all M-stage inputs each cycle unless StallW=1 (hold) or FlushW=1 (valid and regwrite fields cleared, other fields don't-care).
- FlushW and StallW both high: flush wins.
- reset clears the valid and regwrite fields, WriteRegW, and InstRetW to 0. Data fields reset to 0 so ResultW=0 after reset.
- Little-endian load extraction from the registered word, using the registered offset off=ALUOut[1:0]:
  - word: whole word; offset ignored.
  - half: bits [16*off[1] +: 16]; off[0] ignored.
  - byte: bits [8*off +: 8].
  - Extension by LoadUnsigned: zero-extend if 1, else replicate the top bit of the extracted field.
- ResultW mux works on registered fields:
  - 00 and 11: ALUOut.
  - 01: the extended load value.
  - 10: PCPlus8.
- RegWriteW = ValidW & regwrite field & (WriteRegW != 0). Writes to $0 are never issued.
- InstRetW increments by 1 on an edge where ValidW=1 and StallW=0. It wraps modulo 2^CNT_W. A flush does not un-count the instruction currently in W.

## Timing
- Latency one cycle: M inputs sampled at edge N appear on W outputs after edge N and stay valid until edge N+1.
- ResultW, RegWriteW, and WriteRegW are combinational from the pipeline register only. There is no path from M inputs to W outputs within a cycle.
- The register file writes on the following edge. Decode's bypass covers same-cycle reads, so no extra forwarding is required here.
- Stall held for k cycles: outputs stable for k+1 cycles. Repeated identical register writes are permitted and harmless.
- reset asserted mid-stream: the next edge produces a bubble and a zero counter, regardless of StallW or FlushW.

## Structure
- Shared package `mips_pkg`:
  - ResultSrc encodings: RES_ALU, RES_LOAD, RES_LINK.
  - LoadSize encodings: LD_BYTE, LD_HALF, LD_WORD.
  - CNT_W default.
- Sub-module `load_align`: purely combinational. Takes the word, offset, size, and unsigned flag; returns the 32-bit extended value. Reusable by a future data-cache fill path.
- Top level: pipeline register, counter, result mux, write-enable gating.

## Test plan
- Reset then idle: reset=1 for 2 cycles, ValidM=0 -> ValidW=0, RegWriteW=0, ResultW=0, InstRetW=0.
- Byte loads: ReadDataM=0x8899AABB, ALUOutM offset 0..3, signed -> ResultW 0xFFFFFFBB, 0xFFFFFFAA, 0xFFFFFF99, 0xFFFFFF88 one cycle later. With unsigned -> 0x000000BB, 0x000000AA, 0x00000099, 0x00000088.
- Half loads: same word, offset 2, signed -> 0xFFFF8899. Offset 3 -> 0xFFFF8899. Offset 0, unsigned -> 0x0000AABB.
- Link and $0: ResultSrcM=10, PCPlus8M=0x00400010, WriteRegM=31 -> RegWriteW=1, ResultW=0x00400010. Same with WriteRegM=0 -> RegWriteW=0, InstRetW still +1.
- Stall/flush: StallW=1 for 3 cycles -> outputs frozen, InstRetW unchanged. FlushW=StallW=1 -> next cycle ValidW=0, RegWriteW=0.
- Counter wrap with CNT_W=4: 17 valid retirements from reset -> InstRetW=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: result/load encodings, counter width
// default and the MEM/WB pipeline register layout.
package mips_pkg;

  localparam int DEFAULT_CNT_W = 32;

  // Final-result source selected in write-back; the reserved code behaves as ALU
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_LINK = 2'b10,
    RES_RSVD = 2'b11
  } resultSrc_e;

  // Load access width; the reserved code behaves as a full word
  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10,
    LD_RSVD = 2'b11
  } loadSize_e;

  // Everything the W stage needs from the M stage, held for one cycle
  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic [4:0]  writeReg;
    resultSrc_e  resultSrc;
    loadSize_e   loadSize;
    logic        loadUnsigned;
    logic [31:0] aluOut;
    logic [31:0] readData;
    logic [31:0] pcPlus8;
  } memWbReg_t;

  // A register write is only issued for a real instruction that targets
  // something other than $0, which is hard-wired to zero
  function automatic logic isRealWrite(logic valid, logic regWrite, logic [4:0] writeReg);
    return valid & regWrite & (writeReg != 5'd0);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// M-stage to W-stage bundle plus the register-file write port that the
// decode stage reads for its write-through bypass.
interface wb_stage_if #(
  parameter int CNT_W = mips_pkg::DEFAULT_CNT_W
);

  logic              StallW;
  logic              FlushW;
  logic              ValidM;
  logic              RegWriteM;
  logic [4:0]        WriteRegM;
  logic [1:0]        ResultSrcM;
  logic [1:0]        LoadSizeM;
  logic              LoadUnsignedM;
  logic [31:0]       ALUOutM;
  logic [31:0]       ReadDataM;
  logic [31:0]       PCPlus8M;

  logic              ValidW;
  logic              RegWriteW;
  logic [4:0]        WriteRegW;
  logic [31:0]       ResultW;
  logic [CNT_W-1:0]  InstRetW;

  // Pipeline side: drives the M-stage fields and hazard controls
  modport master (
    output StallW, FlushW, ValidM, RegWriteM, WriteRegM, ResultSrcM,
           LoadSizeM, LoadUnsignedM, ALUOutM, ReadDataM, PCPlus8M,
    input  ValidW, RegWriteW, WriteRegW, ResultW, InstRetW
  );

  // Write-back stage side
  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, WriteRegM, ResultSrcM,
           LoadSizeM, LoadUnsignedM, ALUOutM, ReadDataM, PCPlus8M,
    output ValidW, RegWriteW, WriteRegW, ResultW, InstRetW
  );

endinterface

// File: rtl/load_align.sv
// Little-endian sub-word load extraction with sign or zero extension.
// Purely combinational so a cache fill path can reuse it unchanged.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  loadSize_e   size_i,
  input  logic        unsigned_i,
  output logic [31:0] value_o
);

  logic [7:0]  byteField;
  logic [15:0] halfField;

  // Select the addressed byte/halfword and extend it to a full word
  always_comb begin
    byteField = 8'(word_i >> {offset_i, 3'b000});
    halfField = 16'(word_i >> {offset_i[1], 4'b0000});
    value_o   = word_i;
    case (size_i)
      LD_BYTE: value_o = {{24{~unsigned_i & byteField[7]}}, byteField};
      LD_HALF: value_o = {{16{~unsigned_i & halfField[15]}}, halfField};
      default: value_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction, final result
// mux, register-file write-enable gating and retired-instruction counter.
module wb_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic       CLK,
  input  logic       reset,
  wb_stage_if.slave  bus
);

  memWbReg_t         memWb_q;
  memWbReg_t         memWb_d;
  memWbReg_t         mCapture;
  logic [CNT_W-1:0]  instRet_q;
  logic [CNT_W-1:0]  instRet_d;
  logic [31:0]       loadValue;
  logic [31:0]       result;

  // Gather the M-stage inputs into the pipeline register layout
  always_comb begin
    mCapture              = '0;
    mCapture.valid        = bus.ValidM;
    mCapture.regWrite     = bus.RegWriteM;
    mCapture.writeReg     = bus.WriteRegM;
    mCapture.resultSrc    = resultSrc_e'(bus.ResultSrcM);
    mCapture.loadSize     = loadSize_e'(bus.LoadSizeM);
    mCapture.loadUnsigned = bus.LoadUnsignedM;
    mCapture.aluOut       = bus.ALUOutM;
    mCapture.readData     = bus.ReadDataM;
    mCapture.pcPlus8      = bus.PCPlus8M;
  end

  // Next register contents: flush beats stall and inserts a bubble
  always_comb begin
    memWb_d = memWb_q;
    if (bus.FlushW) begin
      memWb_d          = mCapture;
      memWb_d.valid    = 1'b0;
      memWb_d.regWrite = 1'b0;
    end else if (!bus.StallW) begin
      memWb_d = mCapture;
    end
  end

  // An instruction retires on the edge it leaves W; a flush does not undo it
  always_comb begin
    instRet_d = instRet_q;
    if (memWb_q.valid && !bus.StallW) begin
      instRet_d = instRet_q + CNT_W'(1);
    end
  end

  // Pipeline register and counter; reset overrides stall and flush
  always_ff @(posedge CLK) begin
    if (reset) begin
      memWb_q   <= '0;
      instRet_q <= '0;
    end else begin
      memWb_q   <= memWb_d;
      instRet_q <= instRet_d;
    end
  end

  load_align uLoadAlign (
    .word_i     (memWb_q.readData),
    .offset_i   (memWb_q.aluOut[1:0]),
    .size_i     (memWb_q.loadSize),
    .unsigned_i (memWb_q.loadUnsigned),
    .value_o    (loadValue)
  );

  // Final result comes only from registered fields, never from M inputs
  always_comb begin
    result = memWb_q.aluOut;
    case (memWb_q.resultSrc)
      RES_LOAD: result = loadValue;
      RES_LINK: result = memWb_q.pcPlus8;
      default:  result = memWb_q.aluOut;
    endcase
  end

  assign bus.ValidW    = memWb_q.valid;
  assign bus.RegWriteW = isRealWrite(memWb_q.valid, memWb_q.regWrite, memWb_q.writeReg);
  assign bus.WriteRegW = memWb_q.writeReg;
  assign bus.ResultW   = result;
  assign bus.InstRetW  = instRet_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases with literal expectations
// followed by a randomized stream checked every cycle against a record-level
// model. A second instance with a 4-bit counter exercises wrap-around.
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic        StallW, FlushW, ValidM, RegWriteM, LoadUnsignedM;
  logic [4:0]  WriteRegM;
  logic [1:0]  ResultSrcM, LoadSizeM;
  logic [31:0] ALUOutM, ReadDataM, PCPlus8M;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state: what the W stage must present, as plain values
  logic        modelReady = 1'b0;
  logic        mValid, mRegWrite, mKnown;
  logic [4:0]  mRd;
  logic [31:0] mResult;
  logic [31:0] mCnt;

  always #5 CLK = ~CLK;

  wb_stage_if #(.CNT_W(32)) busA ();
  wb_stage_if #(.CNT_W(4))  busB ();

  assign busA.StallW = StallW;         assign busB.StallW = StallW;
  assign busA.FlushW = FlushW;         assign busB.FlushW = FlushW;
  assign busA.ValidM = ValidM;         assign busB.ValidM = ValidM;
  assign busA.RegWriteM = RegWriteM;   assign busB.RegWriteM = RegWriteM;
  assign busA.WriteRegM = WriteRegM;   assign busB.WriteRegM = WriteRegM;
  assign busA.ResultSrcM = ResultSrcM; assign busB.ResultSrcM = ResultSrcM;
  assign busA.LoadSizeM = LoadSizeM;   assign busB.LoadSizeM = LoadSizeM;
  assign busA.LoadUnsignedM = LoadUnsignedM;
  assign busB.LoadUnsignedM = LoadUnsignedM;
  assign busA.ALUOutM = ALUOutM;       assign busB.ALUOutM = ALUOutM;
  assign busA.ReadDataM = ReadDataM;   assign busB.ReadDataM = ReadDataM;
  assign busA.PCPlus8M = PCPlus8M;     assign busB.PCPlus8M = PCPlus8M;

  wb_stage #(.CNT_W(32)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (busA)
  );

  wb_stage #(.CNT_W(4)) dutWrap (
    .CLK   (CLK),
    .reset (reset),
    .bus   (busB)
  );

  // Expected write data computed from the load/link rules with byte arithmetic
  function automatic logic [31:0] modelResult(logic [1:0] src, logic [1:0] size, logic uns,
                                              logic [31:0] alu, logic [31:0] rdata,
                                              logic [31:0] pc8);
    int unsigned bytes[4];
    int unsigned off, lo, v, w;
    longint      r;
    for (int k = 0; k < 4; k++) bytes[k] = (rdata >> (8 * k)) & 32'hFF;
    if (src == 2'd2) return pc8;
    if (src != 2'd1) return alu;
    off = alu % 4;
    if (size == 2'd0) begin
      v = bytes[off];
      w = 8;
    end else if (size == 2'd1) begin
      lo = (off / 2) * 2;
      v = bytes[lo] + 256 * bytes[lo + 1];
      w = 16;
    end else begin
      return rdata;
    end
    r = longint'(v);
    if (!uns && v >= (32'd1 << (w - 1))) r = r - (longint'(1) << w);
    return r[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rw, input logic [4:0] rd,
                               input logic [1:0] src, input logic [1:0] size,
                               input logic uns, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic [31:0] pc8,
                               input logic stall, input logic flush);
    @(negedge CLK);
    reset = 1'b0;
    ValidM = v; RegWriteM = rw; WriteRegM = rd; ResultSrcM = src; LoadSizeM = size;
    LoadUnsignedM = uns; ALUOutM = alu; ReadDataM = rdata; PCPlus8M = pc8;
    StallW = stall; FlushW = flush;
  endtask

  task automatic afterEdge();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: advance the W-stage record on every rising edge
  always @(posedge CLK) begin
    if (reset) begin
      mValid <= 1'b0; mRegWrite <= 1'b0; mRd <= 5'd0; mResult <= 32'd0;
      mKnown <= 1'b1; mCnt <= 32'd0; modelReady <= 1'b1;
    end else if (modelReady) begin
      if (mValid && !StallW) mCnt <= mCnt + 32'd1;
      if (FlushW) begin
        mValid <= 1'b0; mRegWrite <= 1'b0; mKnown <= 1'b0;
      end else if (!StallW) begin
        mValid <= ValidM; mRegWrite <= RegWriteM; mRd <= WriteRegM; mKnown <= 1'b1;
        mResult <= modelResult(ResultSrcM, LoadSizeM, LoadUnsignedM, ALUOutM, ReadDataM, PCPlus8M);
      end
    end
  end

  // Every falling edge: compare both instances against the model
  always @(negedge CLK) begin
    if (modelReady) begin
      checkOutput("cmp ValidW", 32'(busA.ValidW), 32'(mValid));
      checkOutput("cmp RegWriteW", 32'(busA.RegWriteW),
                  32'(mValid && mRegWrite && (mRd != 5'd0)));
      checkOutput("cmp InstRetW", busA.InstRetW, mCnt);
      checkOutput("cmp InstRetW wrap", 32'(busB.InstRetW), 32'(mCnt[3:0]));
      checkOutput("cmp wrap ResultW", busB.ResultW, busA.ResultW);
      if (mKnown) begin
        checkOutput("cmp WriteRegW", 32'(busA.WriteRegW), 32'(mRd));
        checkOutput("cmp ResultW", busA.ResultW, mResult);
      end
    end
  end

  logic [31:0] expSigned[4];
  logic [31:0] expUnsigned[4];

  initial begin
    expSigned   = '{32'hFFFFFFBB, 32'hFFFFFFAA, 32'hFFFFFF99, 32'hFFFFFF88};
    expUnsigned = '{32'h000000BB, 32'h000000AA, 32'h00000099, 32'h00000088};
    reset = 1'b1;
    StallW = 1'b0; FlushW = 1'b0; ValidM = 1'b0; RegWriteM = 1'b0; WriteRegM = 5'd0;
    ResultSrcM = 2'd0; LoadSizeM = 2'd0; LoadUnsignedM = 1'b0;
    ALUOutM = 32'd0; ReadDataM = 32'd0; PCPlus8M = 32'd0;

    // Reset then idle
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset ValidW", 32'(busA.ValidW), 32'd0);
    checkOutput("reset RegWriteW", 32'(busA.RegWriteW), 32'd0);
    checkOutput("reset ResultW", busA.ResultW, 32'd0);
    checkOutput("reset InstRetW", busA.InstRetW, 32'd0);

    // Byte loads, signed then unsigned
    for (int off = 0; off < 4; off++) begin
      applyStimulus(1, 1, 5'd5, 2'b01, 2'b00, 0, 32'(off), 32'h8899AABB, 32'd0, 0, 0);
      afterEdge();
      checkOutput("byte signed", busA.ResultW, expSigned[off]);
    end
    for (int off = 0; off < 4; off++) begin
      applyStimulus(1, 1, 5'd5, 2'b01, 2'b00, 1, 32'h100 + 32'(off), 32'h8899AABB, 32'd0, 0, 0);
      afterEdge();
      checkOutput("byte unsigned", busA.ResultW, expUnsigned[off]);
    end

    // Half loads
    applyStimulus(1, 1, 5'd6, 2'b01, 2'b01, 0, 32'd2, 32'h8899AABB, 32'd0, 0, 0);
    afterEdge();
    checkOutput("half off2 signed", busA.ResultW, 32'hFFFF8899);
    applyStimulus(1, 1, 5'd6, 2'b01, 2'b01, 0, 32'd3, 32'h8899AABB, 32'd0, 0, 0);
    afterEdge();
    checkOutput("half off3 signed", busA.ResultW, 32'hFFFF8899);
    applyStimulus(1, 1, 5'd6, 2'b01, 2'b01, 1, 32'd0, 32'h8899AABB, 32'd0, 0, 0);
    afterEdge();
    checkOutput("half off0 unsigned", busA.ResultW, 32'h0000AABB);

    // Link to $31, then to $0
    applyStimulus(1, 1, 5'd31, 2'b10, 2'b10, 0, 32'hCAFE0000, 32'd0, 32'h00400010, 0, 0);
    afterEdge();
    checkOutput("link RegWriteW", 32'(busA.RegWriteW), 32'd1);
    checkOutput("link ResultW", busA.ResultW, 32'h00400010);
    checkOutput("link InstRetW", busA.InstRetW, 32'd11);
    applyStimulus(1, 1, 5'd0, 2'b10, 2'b10, 0, 32'hCAFE0000, 32'd0, 32'h00400010, 0, 0);
    afterEdge();
    checkOutput("r0 RegWriteW", 32'(busA.RegWriteW), 32'd0);
    checkOutput("r0 InstRetW", busA.InstRetW, 32'd12);
    applyStimulus(0, 0, 5'd0, 2'b00, 2'b00, 0, 32'd0, 32'd0, 32'd0, 0, 0);
    afterEdge();
    checkOutput("r0 retired InstRetW", busA.InstRetW, 32'd13);
    checkOutput("idle ValidW", 32'(busA.ValidW), 32'd0);

    // Stall holds the W stage for three cycles
    applyStimulus(1, 1, 5'd7, 2'b00, 2'b10, 0, 32'h12345678, 32'd0, 32'd0, 0, 0);
    afterEdge();
    checkOutput("pre-stall ResultW", busA.ResultW, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 5'd3, 2'b10, 2'b10, 0, 32'hDEADBEEF, 32'd0, 32'h11111111, 1, 0);
      afterEdge();
      checkOutput("stall ValidW", 32'(busA.ValidW), 32'd1);
      checkOutput("stall WriteRegW", 32'(busA.WriteRegW), 32'd7);
      checkOutput("stall ResultW", busA.ResultW, 32'h12345678);
      checkOutput("stall InstRetW", busA.InstRetW, 32'd13);
    end
    applyStimulus(0, 0, 5'd0, 2'b00, 2'b00, 0, 32'd0, 32'd0, 32'd0, 0, 0);
    afterEdge();
    checkOutput("post-stall InstRetW", busA.InstRetW, 32'd14);

    // Flush together with stall: bubble, and the held instruction is not counted
    applyStimulus(1, 1, 5'd9, 2'b00, 2'b10, 0, 32'h0BADF00D, 32'd0, 32'd0, 0, 0);
    afterEdge();
    applyStimulus(1, 1, 5'd4, 2'b00, 2'b10, 0, 32'h55555555, 32'd0, 32'd0, 1, 1);
    afterEdge();
    checkOutput("flush+stall ValidW", 32'(busA.ValidW), 32'd0);
    checkOutput("flush+stall RegWriteW", 32'(busA.RegWriteW), 32'd0);
    checkOutput("flush+stall InstRetW", busA.InstRetW, 32'd14);

    // Flush alone still counts the instruction leaving W
    applyStimulus(1, 1, 5'd10, 2'b00, 2'b10, 0, 32'h00000042, 32'd0, 32'd0, 0, 0);
    afterEdge();
    applyStimulus(1, 1, 5'd11, 2'b00, 2'b10, 0, 32'h00000043, 32'd0, 32'd0, 0, 1);
    afterEdge();
    checkOutput("flush ValidW", 32'(busA.ValidW), 32'd0);
    checkOutput("flush InstRetW", busA.InstRetW, 32'd15);

    // Counter wrap: 17 retirements from reset on the 4-bit instance
    @(negedge CLK);
    reset = 1'b1;
    afterEdge();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 1, 5'd2, 2'b00, 2'b10, 0, 32'(i), 32'd0, 32'd0, 0, 0);
    end
    applyStimulus(0, 0, 5'd0, 2'b00, 2'b00, 0, 32'd0, 32'd0, 32'd0, 0, 0);
    afterEdge();
    checkOutput("wrap InstRetW 4-bit", 32'(busB.InstRetW), 32'd1);
    checkOutput("wrap InstRetW 32-bit", busA.InstRetW, 32'd17);

    // Randomized stream checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                    2'($urandom), 2'($urandom), 1'($urandom),
                    $urandom, $urandom, $urandom,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 63) == 0) reset = 1'b1;
    end
    @(negedge CLK);
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
